// File: rtl/seven_seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl_pkg
//  Brief    : Shared constants, state encodings and helpers for the
//             time-multiplexed seven-segment scan controller.
//  Revision : 1.0 - initial release
// ============================================================================
package seven_seg_scan_ctrl_pkg;

   // All segments off (segments are active-low)
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Scan FSM encodings
   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_SHOW  = 2'd1;
   localparam logic [1:0] S_GUARD = 2'd2;

   // Larger of two integers, used to size the shared prescaler
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_decoder
//  Brief    : Combinational hex nibble to seven-segment decoder.
//             Output is {a,b,c,d,e,f,g}, active-low (0 = segment lit).
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
   import seven_seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Full hex glyph table: 0-9, A, b, C, d, E, F
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nibble)
         4'h0: o_seg = 7'b0000001;
         4'h1: o_seg = 7'b1001111;
         4'h2: o_seg = 7'b0010010;
         4'h3: o_seg = 7'b0000110;
         4'h4: o_seg = 7'b1001100;
         4'h5: o_seg = 7'b0100100;
         4'h6: o_seg = 7'b0100000;
         4'h7: o_seg = 7'b0001111;
         4'h8: o_seg = 7'b0000000;
         4'h9: o_seg = 7'b0000100;
         4'hA: o_seg = 7'b0001000;
         4'hB: o_seg = 7'b1100000;
         4'hC: o_seg = 7'b0110001;
         4'hD: o_seg = 7'b1000010;
         4'hE: o_seg = 7'b0110000;
         4'hF: o_seg = 7'b0111000;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl
//  Brief    : Scans NUM_DIGITS common-anode digits through one shared
//             decoder, with an all-off guard gap between digits. New values
//             arrive over valid/ready and are committed only at frame
//             boundaries so a frame never mixes old and new digits.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
   import seven_seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    enable,
   input  logic                    lz_suppress,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic                    load_ready,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    frame_done
);

   localparam int c_cnt_w  = $clog2(max_int(REFRESH_DIV, GUARD_CYCLES));
   localparam int c_idx_w  = $clog2(NUM_DIGITS);
   localparam int c_data_w = 4 * NUM_DIGITS;

   localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(REFRESH_DIV - 1);
   localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD_CYCLES - 1);
   localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

   logic [1:0]            r_state;
   logic [1:0]            w_state_next;
   logic [c_idx_w-1:0]    r_idx;
   logic [c_idx_w-1:0]    w_idx_next;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_cnt_w-1:0]    w_cnt_next;

   logic [c_data_w-1:0]   r_disp;
   logic [c_data_w-1:0]   r_pend;
   logic                  r_pend_full;
   logic [c_data_w-1:0]   w_disp_next;
   logic                  w_accept;
   logic                  w_commit;
   logic                  w_frame_end;

   logic [3:0]            w_nibble;
   logic [6:0]            w_dec_seg;
   logic                  w_blank;
   logic                  w_lit;
   logic [NUM_DIGITS-1:0] w_an_next;
   logic [6:0]            w_seg_next;
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;

   // Last cycle of the frame: final guard cycle of the highest digit
   assign w_frame_end = (r_state == S_GUARD) && (r_idx == c_idx_last) &&
                        (r_cnt == c_guard_last);

   // Pending slot accepts only when empty; commit at the frame seam or when dark
   assign w_accept    = load_valid && !r_pend_full;
   assign w_commit    = r_pend_full &&
                        ((r_state == S_OFF) || (w_frame_end && enable));
   assign w_disp_next = w_commit ? r_pend : r_disp;
   assign load_ready  = ~r_pend_full;

   // FSM state, digit index and shared prescaler
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_OFF;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state: dwell REFRESH_DIV in SHOW, GUARD_CYCLES in GUARD; prescaler restarts on every state change
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_cnt_next   = r_cnt + c_cnt_w'(1);
      if (!enable) begin
         w_state_next = S_OFF;
         w_idx_next   = '0;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            S_OFF: begin
               w_state_next = S_SHOW;
               w_idx_next   = '0;
               w_cnt_next   = '0;
            end
            S_SHOW: begin
               if (r_cnt == c_show_last) begin
                  w_state_next = S_GUARD;
                  w_cnt_next   = '0;
               end
            end
            S_GUARD: begin
               if (r_cnt == c_guard_last) begin
                  w_state_next = S_SHOW;
                  w_cnt_next   = '0;
                  w_idx_next   = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
               end
            end
            default: begin
               w_state_next = S_OFF;
               w_idx_next   = '0;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   // Pending slot and committed display value
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_disp      <= '0;
      end else begin
         if (w_commit) begin
            r_disp      <= r_pend;
            r_pend_full <= 1'b0;
         end
         if (w_accept) begin
            r_pend      <= load_data;
            r_pend_full <= 1'b1;
         end
      end
   end

   // Nibble mux: pick the digit that will be shown after the coming edge
   always_comb begin
      w_nibble = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx_next == c_idx_w'(i)) begin
            w_nibble = w_disp_next[4*i +: 4];
         end
      end
   end

   seven_seg_decoder u_decoder (
      .i_nibble (w_nibble),
      .o_seg    (w_dec_seg)
   );

   // Output decode: blanking, one-hot-low anode and frame pulse
   always_comb begin
      w_blank = 1'b0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (lz_suppress && (w_idx_next == c_idx_w'(i)) &&
             ((w_disp_next >> (4 * i)) == '0)) begin
            w_blank = 1'b1;
         end
      end
      w_lit = (w_state_next == S_SHOW) && !w_blank;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_an_next[i] = ~(w_lit && (w_idx_next == c_idx_w'(i)));
      end
      w_seg_next = w_lit ? w_dec_seg : SEG_BLANK;
      frame_done = w_frame_end;
   end

   // Register anode and segments together so the pins switch in the same edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_an  <= '1;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= w_an_next;
         r_seg <= w_seg_next;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;

endmodule
`default_nettype wire
